// File: rtl/chrono_pkg.sv
// Shared types, segment encodings and helpers for the chrono_lap stopwatch.
package chrono_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   // MM:SS.cc held as six BCD digits, most significant first.
   typedef struct packed {
      logic [3:0] m_t;
      logic [3:0] m_o;
      logic [3:0] s_t;
      logic [3:0] s_o;
      logic [3:0] c_t;
      logic [3:0] c_o;
   } bcd_t;

   // Segment order a..g left to right, active-low.
   localparam logic [0:6] SEG_0 = 7'b0000001;
   localparam logic [0:6] SEG_1 = 7'b1001111;
   localparam logic [0:6] SEG_2 = 7'b0010010;
   localparam logic [0:6] SEG_3 = 7'b0000110;
   localparam logic [0:6] SEG_4 = 7'b1001100;
   localparam logic [0:6] SEG_5 = 7'b0100100;
   localparam logic [0:6] SEG_6 = 7'b0100000;
   localparam logic [0:6] SEG_7 = 7'b0001111;
   localparam logic [0:6] SEG_8 = 7'b0000000;
   localparam logic [0:6] SEG_9 = 7'b0000100;
   localparam logic [0:6] SEG_OFF = 7'b1111111;

   localparam int CLK_HZ_DEF  = 50_000_000;
   localparam int TICK_HZ_DEF = 100;
   localparam int TICK_DIV    = CLK_HZ_DEF / TICK_HZ_DEF;

   function automatic int tick_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic logic [0:6] bcd_to_seg(input logic [3:0] d);
      logic [0:6] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/chrono_btn.sv
// Button conditioner: 2-flop synchroniser, debounce counter, 1-cycle press pulse on falling edge.
module chrono_btn
   import chrono_pkg::*;
#(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          s1, s2, deb;
   logic [CW-1:0] cnt;
   logic          hit;

   // The new level is accepted after DEB_CYCLES consecutive cycles differing from deb.
   assign hit = (s2 != deb) && (cnt == CW'(DEB_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         deb   <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= key;
         s2    <= s1;
         press <= hit && !s2;
         if (s2 == deb) begin
            cnt <= '0;
         end else if (hit) begin
            deb <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/chrono_lap.sv
// MM:SS.cc stopwatch/count-down timer with lap freeze, driving six seven-segment displays.
module chrono_lap
   import chrono_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 100,
   parameter int DEB_CYCLES = 1_000_000,
   parameter int MAX_MIN    = 59
) (
   input  logic       MAX10_CLK2_50,
   input  logic       SW0,
   input  logic       KEY0,
   input  logic       KEY1,
   input  logic       SW1,
   input  logic [5:0] SW_PRESET,
   output logic [0:6] HEX0,
   output logic [0:6] HEX1,
   output logic [0:6] HEX2,
   output logic [0:6] HEX3,
   output logic [0:6] HEX4,
   output logic [0:6] HEX5,
   output logic       LEDR0,
   output logic       LEDR1,
   output logic       LEDR2
);

   localparam int DIV = tick_div(CLK_HZ, TICK_HZ);
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

   logic clk, rst;
   assign clk = MAX10_CLK2_50;
   assign rst = SW0;

   logic k0, k1;

   chrono_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn0 (.clk(clk), .rst(rst), .key(KEY0), .press(k0));
   chrono_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn1 (.clk(clk), .rst(rst), .key(KEY1), .press(k1));

   state_t        state, nstate;
   logic          lap, lap_n, dir;
   logic [PW-1:0] pre;
   logic          tick;
   bcd_t          cnt, snap, up, dn, preset_cnt, disp;
   logic          down_zero;
   logic [6:0]    preset_sat;

   function automatic logic [4:0] dinc(input logic [3:0] d, input logic [3:0] top, input logic en);
      if (!en)           return {1'b0, d};
      else if (d == top) return {1'b1, 4'd0};
      else               return {1'b0, d + 4'd1};
   endfunction

   function automatic logic [4:0] ddec(input logic [3:0] d, input logic [3:0] top, input logic en);
      if (!en)           return {1'b0, d};
      else if (d == 4'd0) return {1'b1, top};
      else               return {1'b0, d - 4'd1};
   endfunction

   assign preset_sat = (int'(SW_PRESET) > MAX_MIN) ? 7'(MAX_MIN) : {1'b0, SW_PRESET};

   always_comb begin
      preset_cnt     = '0;
      preset_cnt.m_t = 4'(preset_sat / 7'd10);
      preset_cnt.m_o = 4'(preset_sat % 7'd10);
   end

   assign tick = (state == RUN) && (pre == PW'(DIV - 1));

   // Up: ripple carries; MAX_MIN:59.99 wraps to zero.
   always_comb begin
      logic c1, c2, c3, c4, c5;
      up = cnt;
      {c1, up.c_o} = dinc(cnt.c_o, 4'd9, 1'b1);
      {c2, up.c_t} = dinc(cnt.c_t, 4'd9, c1);
      {c3, up.s_o} = dinc(cnt.s_o, 4'd9, c2);
      {c4, up.s_t} = dinc(cnt.s_t, 4'd5, c3);
      c5 = 1'b0;
      if (c4 && cnt.m_t == MAX_T && cnt.m_o == MAX_O) begin
         up.m_t = 4'd0;
         up.m_o = 4'd0;
      end else begin
         {c5, up.m_o} = dinc(cnt.m_o, 4'd9, c4);
         up.m_t = cnt.m_t + {3'd0, c5};
      end
   end

   // Down: ripple borrows; zero is never decremented.
   always_comb begin
      logic b1, b2, b3, b4, b5;
      dn = cnt;
      {b1, dn.c_o} = ddec(cnt.c_o, 4'd9, 1'b1);
      {b2, dn.c_t} = ddec(cnt.c_t, 4'd9, b1);
      {b3, dn.s_o} = ddec(cnt.s_o, 4'd9, b2);
      {b4, dn.s_t} = ddec(cnt.s_t, 4'd5, b3);
      {b5, dn.m_o} = ddec(cnt.m_o, 4'd9, b4);
      dn.m_t = cnt.m_t - {3'd0, b5};
      if (cnt == '0) dn = '0;
   end

   assign down_zero = (dn == '0);

   always_comb begin
      nstate = state;
      lap_n  = lap;
      case (state)
         IDLE: begin
            if (k0) nstate = RUN;
         end
         RUN: begin
            if (tick && dir && down_zero) begin
               nstate = DONE;
               lap_n  = 1'b0;
            end else if (k0) begin
               nstate = PAUSE;
            end else if (k1) begin
               lap_n = !lap;
            end
         end
         PAUSE: begin
            if (k0) begin
               nstate = RUN;
            end else if (k1) begin
               nstate = IDLE;
               lap_n  = 1'b0;
            end
         end
         DONE: begin
            if (k1) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lap   <= 1'b0;
         dir   <= 1'b0;
         pre   <= '0;
         cnt   <= '0;
         snap  <= '0;
      end else begin
         state <= nstate;
         lap   <= lap_n;
         if (state == IDLE) dir <= SW1;
         // Prescaler is cleared in IDLE and simply holds in PAUSE/DONE.
         if (state == IDLE)     pre <= '0;
         else if (state == RUN) pre <= tick ? '0 : pre + 1'b1;
         if (state == IDLE)     cnt <= SW1 ? preset_cnt : '0;
         else if (tick)         cnt <= dir ? dn : up;
         if (lap_n && !lap)     snap <= cnt;
      end
   end

   assign disp = lap ? snap : cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         HEX0  <= SEG_0;
         HEX1  <= SEG_0;
         HEX2  <= SEG_0;
         HEX3  <= SEG_0;
         HEX4  <= SEG_0;
         HEX5  <= SEG_0;
         LEDR0 <= 1'b0;
         LEDR1 <= 1'b0;
         LEDR2 <= 1'b0;
      end else begin
         HEX0  <= bcd_to_seg(disp.c_o);
         HEX1  <= bcd_to_seg(disp.c_t);
         HEX2  <= bcd_to_seg(disp.s_o);
         HEX3  <= bcd_to_seg(disp.s_t);
         HEX4  <= bcd_to_seg(disp.m_o);
         HEX5  <= bcd_to_seg(disp.m_t);
         LEDR0 <= (state == RUN);
         LEDR1 <= lap;
         LEDR2 <= (state == DONE);
      end
   end

endmodule

// File: tb/tb_chrono_lap.sv
// Directed bench for chrono_lap: one instance with MAX_MIN=59, one with MAX_MIN=0 run in parallel.
module tb_chrono_lap;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic done_b = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: MAX_MIN = 59
   logic       rsta = 1'b0, k0a = 1'b1, k1a = 1'b1, sw1a = 1'b0;
   logic [5:0] pra = 6'd0;
   logic [0:6] a0, a1, a2, a3, a4, a5;
   logic       la0, la1, la2;

   chrono_lap #(.CLK_HZ(1000), .TICK_HZ(100), .DEB_CYCLES(4), .MAX_MIN(59)) dut_a (
      .MAX10_CLK2_50(clk), .SW0(rsta), .KEY0(k0a), .KEY1(k1a), .SW1(sw1a), .SW_PRESET(pra),
      .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5),
      .LEDR0(la0), .LEDR1(la1), .LEDR2(la2));

   // DUT B: MAX_MIN = 0
   logic       rstb = 1'b0, k0b = 1'b1, k1b = 1'b1, sw1b = 1'b0;
   logic [5:0] prb = 6'd0;
   logic [0:6] b0, b1, b2, b3, b4, b5;
   logic       lb0, lb1, lb2;

   chrono_lap #(.CLK_HZ(1000), .TICK_HZ(100), .DEB_CYCLES(4), .MAX_MIN(0)) dut_b (
      .MAX10_CLK2_50(clk), .SW0(rstb), .KEY0(k0b), .KEY1(k1b), .SW1(sw1b), .SW_PRESET(prb),
      .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5),
      .LEDR0(lb0), .LEDR1(lb1), .LEDR2(lb2));

   logic [41:0] hexa, hexb;
   logic [2:0]  leda, ledb;
   assign hexa = {a5, a4, a3, a2, a1, a0};
   assign hexb = {b5, b4, b3, b2, b1, b0};
   assign leda = {la2, la1, la0};
   assign ledb = {lb2, lb1, lb0};

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [41:0] dispv(input int m, input int s, input int c);
      return {seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10), seg(c / 10), seg(c % 10)};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Returns at the negedge after posedge number c.
   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic press_a(input logic [1:0] m, input int at);
      wait_until(at);
      if (m[0]) k0a = 1'b0;
      if (m[1]) k1a = 1'b0;
      wait_until(at + 10);
      k0a = 1'b1;
      k1a = 1'b1;
   endtask

   task automatic press_b(input logic [1:0] m, input int at);
      wait_until(at);
      if (m[0]) k0b = 1'b0;
      if (m[1]) k1b = 1'b0;
      wait_until(at + 10);
      k0b = 1'b1;
      k1b = 1'b1;
   endtask

   initial begin
      #2 rsta = 1'b1;
      wait_until(2);
      check("a_rst_hex", hexa, dispv(0, 0, 0));
      check("a_rst_led", leda, 3'b000);
      wait_until(3);
      rsta = 1'b0;

      // Start at 10: RUN from edge 17, tick n lands on edge 17+10n.
      press_a(2'b01, 10);
      wait_until(20);
      check("a_run_led", leda, 3'b001);
      wait_until(10022);
      check("a_1000t_hex", hexa, dispv(0, 10, 0));
      check("a_1000t_led", leda, 3'b001);

      press_a(2'b01, 10030);
      wait_until(10045);
      check("a_pause_hex", hexa, dispv(0, 10, 2));
      check("a_pause_led", leda, 3'b000);
      wait_until(10100);
      check("a_pause_hold", hexa, dispv(0, 10, 2));
      press_a(2'b10, 10110);
      wait_until(10125);
      check("a_clr_hex", hexa, dispv(0, 0, 0));
      check("a_clr_led", leda, 3'b000);

      // Lap: RUN from 10207, freeze at edge 11210 after tick 100.
      press_a(2'b01, 10200);
      press_a(2'b10, 11203);
      wait_until(13215);
      check("a_lap_hex", hexa, dispv(0, 1, 0));
      check("a_lap_led", leda, 3'b011);
      press_a(2'b10, 13220);
      wait_until(13230);
      check("a_unlap_hex", hexa, dispv(0, 3, 2));
      check("a_unlap_led", leda, 3'b001);

      // Three-clock glitch on KEY0 must be rejected.
      wait_until(13300);
      k0a = 1'b0;
      wait_until(13303);
      k0a = 1'b1;
      wait_until(13320);
      check("a_glitch_led", leda, 3'b001);
      check("a_glitch_hex", hexa, dispv(0, 3, 11));

      // Both keys together: pause at edge 13407, coinciding with tick 320.
      press_a(2'b11, 13400);
      wait_until(13415);
      check("a_both_hex", hexa, dispv(0, 3, 20));
      check("a_both_led", leda, 3'b000);
      press_a(2'b10, 13430);

      // Asynchronous reset at 00:05.37.
      press_a(2'b01, 13500);
      wait_until(18870);
      check("a_prerst_hex", hexa, dispv(0, 5, 36));
      wait_until(18880);
      check("a_537_hex", hexa, dispv(0, 5, 37));
      #2 rsta = 1'b1;
      #1;
      check("a_async_hex", hexa, dispv(0, 0, 0));
      check("a_async_led", leda, 3'b000);
      wait_until(18885);
      rsta = 1'b0;
      wait_until(18888);
      check("a_postrst_hex", hexa, dispv(0, 0, 0));
      check("a_postrst_led", leda, 3'b000);

      // Count-down from a saturated then a legal preset.
      wait_until(18890);
      sw1a = 1'b1;
      pra  = 6'd63;
      wait_until(18895);
      check("a_sat_hex", hexa, dispv(59, 0, 0));
      wait_until(18897);
      pra = 6'd1;
      wait_until(18910);
      check("a_preset_hex", hexa, dispv(1, 0, 0));
      press_a(2'b01, 18920);
      wait_until(18940);
      check("a_dn1_hex", hexa, dispv(0, 59, 99));
      wait_until(19000);
      sw1a = 1'b0;
      pra  = 6'd3;
      wait_until(19005);
      check("a_dnsw_hex", hexa, dispv(0, 59, 93));
      wait_until(78920);
      check("a_dnlast_hex", hexa, dispv(0, 0, 1));
      check("a_dnlast_led", leda, 3'b001);
      wait_until(78935);
      check("a_done_hex", hexa, dispv(0, 0, 0));
      check("a_done_led", leda, 3'b100);
      press_a(2'b01, 79000);
      wait_until(79500);
      sw1a = 1'b1;
      pra  = 6'd1;
      wait_until(79940);
      check("a_donehold_hex", hexa, dispv(0, 0, 0));
      check("a_donehold_led", leda, 3'b100);
      press_a(2'b10, 80000);
      wait_until(80020);
      check("a_doneclr_hex", hexa, dispv(1, 0, 0));
      check("a_doneclr_led", leda, 3'b000);

      while (!done_b && cyc < 90000) @(negedge clk);
      check("b_finished", {63'd0, done_b}, 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2 rstb = 1'b1;
      wait_until(3);
      rstb = 1'b0;
      press_b(2'b01, 10);
      wait_until(60010);
      check("b_5999_hex", hexb, dispv(0, 59, 99));
      wait_until(60020);
      check("b_wrap_hex", hexb, dispv(0, 0, 0));
      check("b_wrap_led", ledb, 3'b001);
      wait_until(60030);
      check("b_after_wrap", hexb, dispv(0, 0, 1));
      press_b(2'b01, 60040);
      press_b(2'b10, 60070);
      wait_until(60080);
      sw1b = 1'b1;
      prb  = 6'd5;
      wait_until(60090);
      check("b_sat_hex", hexb, dispv(0, 0, 0));
      check("b_sat_led", ledb, 3'b000);
      // Preset 0 in down mode: DONE on the first tick (edge 60117).
      press_b(2'b01, 60100);
      wait_until(60112);
      check("b_p0_run_led", ledb, 3'b001);
      wait_until(60125);
      check("b_p0_done_led", ledb, 3'b100);
      check("b_p0_done_hex", hexb, dispv(0, 0, 0));
      done_b = 1'b1;
   end

endmodule
